seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes the 4-digit common-anode 7-segment display between two 2-digit segment-pattern sources: player A (digits 3..2) and player B or timer (digits 1..0).
- Sequences anode scanning with a blanking gap between digits (anti-ghosting), latches patterns per digit, supports whole-display blink.
- Sits between the digit-decode blocks and the board's an/seg/dp pins.

Parameters:
- TICK_DIV, 100000, clock cycles per digit SHOW period; must be >= 2.
- BLANK_CYCLES, 1000, clock cycles of all-anodes-off between digits; must be >= 1.
- BLINK_FRAMES, 125, full scan frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scan; 0 = display dark.
- blink  in  1  1 = blink the whole display.
- seg_a_hi  in  7  active-low pattern for digit 3 (leftmost).
- seg_a_lo  in  7  digit 2 pattern.
- seg_b_hi  in  7  digit 1 pattern.
- seg_b_lo  in  7  digit 0 pattern (rightmost).
- dp_mask  in  4  active-high decimal-point request; bit i = digit i.
- an  out  4  active-low anodes; an[i] = digit i.
- seg  out  7  active-low segments.
- dp  out  1  active-low decimal point.
- digit_idx  out  2  digit currently selected, or next to be shown during BLANK.
- frame_done  out  1  single-cycle pulse at end of each frame.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, digit_idx=0, frame_done=0.
  - Internal: state=BLANK, cycle counter=0, frame counter=0, blink phase=ON.
- Reset asserted mid-operation: same values on the next edge, regardless of state.
- All outputs are registered. an, seg and dp update on the same edge; no combinational path from inputs to outputs.
- States: IDLE, BLANK, SHOW.
  - BLANK:
    - Drives an=1111, seg=1111111, dp=1.
    - Counter runs 0..BLANK_CYCLES-1.
    - On the terminal count, goes to SHOW and latches the pattern selected by digit_idx: 0=seg_b_lo, 1=seg_b_hi, 2=seg_a_lo, 3=seg_a_hi.
    - Also latches dp = ~dp_mask[digit_idx] on that edge.
  - SHOW:
    - an[digit_idx]=0, all other anodes 1; seg/dp from the latched values.
    - Input changes during SHOW are ignored until the next latch.
    - Counter runs 0..TICK_DIV-1. On the terminal count: go to BLANK, digit_idx increments modulo 4, counter clears.
  - SHOW exit with digit_idx=3: digit_idx wraps to 0 and frame_done=1 for exactly that one cycle.
- Frame length is 4*(TICK_DIV+BLANK_CYCLES) cycles.
- Blink:
  - Frame counter counts frame_done pulses 0..BLINK_FRAMES-1. At its terminal count it wraps and toggles blink phase.
  - blink=1 and phase=OFF: SHOW drives an=1111, but timing and digit_idx advance unchanged.
  - blink=0: phase keeps toggling and has no visible effect.
- Enable:
  - enable=0 in any state: next edge goes to IDLE, outputs dark, digit_idx=0, counters clear, frame_done=0.
  - IDLE with enable=1: go to BLANK with digit_idx=0, counter=0.
  - Blink phase holds its value while in IDLE.
- Priority: reset > enable=0 > counter-terminal transitions.

Test Plan (TICK_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2):
- Reset release, enable=1, seg_a_hi=7'h79, seg_a_lo=7'h24, seg_b_hi=7'h30, seg_b_lo=7'h40, dp_mask=0.
  - Expect 2 cycles an=1111, then 8 cycles an=1110 with seg=7'h40.
  - Then 2 blank, then an=1101 with seg=7'h30, then an=1011/7'h24, then an=0111/7'h79.
  - frame_done pulses once per 40 cycles; dp=1 throughout.
- Change seg_b_lo to 7'h79 mid-SHOW of digit 0 -> seg unchanged until the next digit-0 SHOW, which shows 7'h79.
- dp_mask=4'b0100 -> dp=0 only while an=1011; dp=1 during BLANK and all other digits.
- blink=1 for 6 frames -> frames 1-2 lit, 3-4 an=1111 throughout, 5-6 lit. frame_done and digit_idx keep cycling.
- enable=0 during SHOW of digit 2 -> next edge an=1111, digit_idx=0. enable=1 -> 2 blank cycles, then digit 0 shows.
- reset asserted during SHOW of digit 3 with blink phase OFF -> next edge all outputs at reset values, phase ON. The sequence restarts identically to the first scenario.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bundle of the segment-pattern sources, scan controls and display pins
// shared between the digit-decode side and the scan controller.
interface seg_scan_if;
  logic       enable;
  logic       blink;
  logic [6:0] seg_a_hi;
  logic [6:0] seg_a_lo;
  logic [6:0] seg_b_hi;
  logic [6:0] seg_b_lo;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;
  logic       frame_done;

  // Handshake: there is no valid/ready pair. Pattern and control inputs are
  // level-sampled on every clock edge. A pattern only takes effect on the
  // edge that moves a digit from BLANK to SHOW.
  modport master (
    output enable, blink, seg_a_hi, seg_a_lo, seg_b_hi, seg_b_lo, dp_mask,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  enable, blink, seg_a_hi, seg_a_lo, seg_b_hi, seg_b_lo, dp_mask,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scanner: a blanking gap between digits,
// per-digit pattern latching and whole-display blink.
module seg_scan_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan_if.slave   bus,
  output logic [1:0]  state_dbg
);
  localparam int CMAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   fcnt;
  logic            phase_on;
  logic [6:0]      pattern;
  logic [3:0]      show_an;

  assign state_dbg = state;

  always_comb begin
    pattern = bus.seg_b_lo;
    case (bus.digit_idx)
      2'd0: pattern = bus.seg_b_lo;
      2'd1: pattern = bus.seg_b_hi;
      2'd2: pattern = bus.seg_a_lo;
      2'd3: pattern = bus.seg_a_hi;
      default: pattern = bus.seg_b_lo;
    endcase
  end

  // Blink only hides the anodes; scan timing keeps running underneath.
  always_comb begin
    show_an = ~(4'b0001 << bus.digit_idx);
    if (bus.blink && !phase_on) show_an = 4'b1111;
  end

  always_ff @(posedge clk) begin
    bus.frame_done <= 1'b0;
    if (reset) begin
      state         <= BLANK;
      cnt           <= '0;
      fcnt          <= '0;
      phase_on      <= 1'b1;
      bus.digit_idx <= 2'd0;
      bus.an        <= 4'b1111;
      bus.seg       <= 7'h7f;
      bus.dp        <= 1'b1;
    end else if (!bus.enable) begin
      state         <= IDLE;
      cnt           <= '0;
      fcnt          <= '0;
      bus.digit_idx <= 2'd0;
      bus.an        <= 4'b1111;
      bus.seg       <= 7'h7f;
      bus.dp        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state         <= BLANK;
          cnt           <= '0;
          bus.digit_idx <= 2'd0;
        end
        BLANK: begin
          if (cnt == CW'(BLANK_CYCLES - 1)) begin
            state   <= SHOW;
            cnt     <= '0;
            bus.an  <= show_an;
            bus.seg <= pattern;
            bus.dp  <= ~bus.dp_mask[bus.digit_idx];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          bus.an <= show_an;
          if (cnt == CW'(TICK_DIV - 1)) begin
            state         <= BLANK;
            cnt           <= '0;
            bus.an        <= 4'b1111;
            bus.seg       <= 7'h7f;
            bus.dp        <= 1'b1;
            bus.digit_idx <= bus.digit_idx + 2'd1;
            if (bus.digit_idx == 2'd3) begin
              bus.frame_done <= 1'b1;
              if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt     <= '0;
                phase_on <= ~phase_on;
              end else begin
                fcnt <= fcnt + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, checked
// against a frame-position model of the scan sequence.
module tb_seg_scan_ctrl;
  localparam int TD  = 8;
  localparam int BC  = 2;
  localparam int BF  = 2;
  localparam int PER = TD + BC;
  localparam int FL  = 4 * PER;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  seg_scan_if bus ();

  seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: position within the frame plus idle flag, phase and frame count.
  int         m_t;
  bit         m_idle;
  bit         m_phase;
  int         m_fcnt;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [1:0] e_idx;
  logic       e_fd;

  function automatic logic [6:0] pat_of(int d);
    case (d)
      0: return bus.seg_b_lo;
      1: return bus.seg_b_hi;
      2: return bus.seg_a_lo;
      default: return bus.seg_a_hi;
    endcase
  endfunction

  function automatic bit showing(int d);
    return !m_idle && (m_t % PER) >= BC && (m_t / PER) == d;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  task automatic tick();
    int d;
    if (reset) begin
      m_t = 0; m_idle = 0; m_phase = 1; m_fcnt = 0; e_fd = 0;
    end else if (!bus.enable) begin
      m_idle = 1; m_t = 0; m_fcnt = 0; e_fd = 0;
    end else if (m_idle) begin
      m_idle = 0; m_t = 0; e_fd = 0;
    end else begin
      m_t = (m_t + 1) % FL;
      e_fd = (m_t == 0);
      if (m_t % PER == BC) begin
        d = m_t / PER;
        m_seg = pat_of(d);
        m_dp = ~bus.dp_mask[d];
      end
      if (e_fd) begin
        m_fcnt++;
        if (m_fcnt == BF) begin m_fcnt = 0; m_phase = !m_phase; end
      end
    end
    d = m_t / PER;
    if (!m_idle && (m_t % PER) >= BC) begin
      e_an  = (bus.blink && !m_phase) ? 4'b1111 : ~(4'b0001 << d);
      e_seg = m_seg;
      e_dp  = m_dp;
    end else begin
      e_an = 4'b1111; e_seg = 7'h7f; e_dp = 1'b1;
    end
    e_idx = m_idle ? 2'd0 : 2'(d);
    @(posedge clk);
    #1;
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("digit_idx", 32'(bus.digit_idx), 32'(e_idx));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_show(int d, bit need_off, string tag);
    int k;
    k = 0;
    while (!(showing(d) && (!need_off || !m_phase)) && k < 400) begin
      tick();
      k++;
    end
    vectors++;
    if (k >= 400) begin
      miscompares++;
      $error("FAIL %s: wait timed out after %0d cycles, expected SHOW of digit %0d", tag, k, d);
    end
  endtask

  int fd_seen;

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1; bus.blink = 1'b0; bus.dp_mask = 4'b0000;
    bus.seg_a_hi = 7'h79; bus.seg_a_lo = 7'h24;
    bus.seg_b_hi = 7'h30; bus.seg_b_lo = 7'h40;
    run(2);
    reset = 1'b0;
    // Basic scan: frame_done should pulse once per 40 cycles.
    fd_seen = 0;
    for (int i = 0; i < FL; i++) begin
      tick();
      if (bus.frame_done) fd_seen++;
    end
    check("fd_per_frame", 32'(fd_seen), 32'd1);

    // Mid-SHOW pattern change is held off until the next digit-0 latch.
    wait_show(0, 0, "wait_d0");
    run(3);
    bus.seg_b_lo = 7'h79;
    run(FL + 5);

    bus.dp_mask = 4'b0100;
    run(FL);

    bus.blink = 1'b1;
    run(6 * FL);
    bus.blink = 1'b0;

    wait_show(2, 0, "wait_d2");
    run(2);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    run(PER + 5);

    bus.blink = 1'b1;
    wait_show(3, 1, "wait_d3_off");
    run(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.blink = 1'b0; bus.dp_mask = 4'b0000;
    bus.seg_b_lo = 7'h40;
    run(FL);

    // Random traffic: patterns change at arbitrary times, occasional
    // blink toggles, disables and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.seg_a_hi = 7'($urandom); bus.seg_a_lo = 7'($urandom);
        bus.seg_b_hi = 7'($urandom); bus.seg_b_lo = 7'($urandom);
        bus.dp_mask  = 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) bus.blink = ~bus.blink;
      bus.enable = ($urandom_range(0, 149) != 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    bus.enable = 1'b1;
    run(FL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
